// File: rtl/fp32_adder.sv
// fp32_adder: multi-cycle IEEE-754 binary32 add/sub, round to nearest even.
// Define FP32_DENORM_EN for full denormal support; otherwise flush-to-zero.
module fp32_adder (
  input  logic        clk,
  input  logic        reset,
  input  logic        op,
  input  logic        rd,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] z,
  output logic        wr
);
  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic [31:0] z_q, z_d, res_q, res_d;
  logic        op_q, op_d, wr_q, wr_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic        spec_q, spec_d;
  logic [9:0]  e_q, e_d;
  logic [7:0]  eb_q, eb_d;
  logic [27:0] ma_q, ma_d;
  logic [26:0] mb_q, mb_d;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic [7:0]  xe, ye, xee, yee;
  logic [23:0] xm, ym;
  logic        xnan, ynan, xinf, yinf, ysgn;

  assign xe   = x_q[30:23];
  assign ye   = y_q[30:23];
  assign xnan = (&xe) & (|x_q[22:0]);
  assign ynan = (&ye) & (|y_q[22:0]);
  assign xinf = (&xe) & ~(|x_q[22:0]);
  assign yinf = (&ye) & ~(|y_q[22:0]);
  assign ysgn = y_q[31] ^ op_q;
  assign xee  = (|xe) ? xe : 8'd1;
  assign yee  = (|ye) ? ye : 8'd1;
`ifdef FP32_DENORM_EN
  assign xm = {|xe, x_q[22:0]};
  assign ym = {|ye, y_q[22:0]};
`else
  assign xm = (|xe) ? {1'b1, x_q[22:0]} : 24'd0;
  assign ym = (|ye) ? {1'b1, y_q[22:0]} : 24'd0;
`endif

  logic        swap;
  logic [7:0]  dexp;
  logic [26:0] big_m, sml_m, sml_sh, b_al;

  assign swap  = {eb_q, mb_q} > {e_q[7:0], ma_q[26:0]};
  assign big_m = swap ? mb_q : ma_q[26:0];
  assign sml_m = swap ? ma_q[26:0] : mb_q;
  assign dexp  = swap ? (eb_q - e_q[7:0])
                      : (e_q[7:0] - eb_q);

  // Bit 0 of the aligned mantissa is the sticky bit.
  always_comb begin
    sml_sh = '0;
    b_al   = '0;
    if (dexp >= 8'd27) begin
      b_al = {26'd0, |sml_m};
    end else begin
      sml_sh = sml_m >> dexp;
      b_al   = {sml_sh[26:1], sml_sh[0] |
                (|(sml_m & ~(27'h7FFFFFF << dexp)))};
    end
  end

  logic [27:0] sum;
  assign sum = (sa_q == sb_q)
    ? ({1'b0, ma_q[26:0]} + {1'b0, mb_q})
    : ({1'b0, ma_q[26:0]} - {1'b0, mb_q});

  logic [4:0] lz, sh;
  assign lz = lzc27(ma_q[26:0]);
`ifdef FP32_DENORM_EN
  logic [9:0] lim;
  assign lim = e_q - 10'd1;
  assign sh  = ({5'd0, lz} > lim) ? lim[4:0] : lz;
`else
  assign sh = lz;
`endif

  logic        up;
  logic [24:0] mr;
  logic [9:0]  er;
  logic [31:0] rnd_z;

  always_comb begin
    up = ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]);
    mr = {1'b0, ma_q[26:3]} + {24'd0, up};
    er = e_q;
    if (mr[24]) begin
      mr = mr >> 1;
      er = e_q + 10'd1;
    end
    rnd_z = {sa_q, (mr[23] ? er[7:0] : 8'd0), mr[22:0]};
    if (!er[9] && er >= 10'd255)
      rnd_z = {sa_q, 8'hFF, 23'd0};
`ifndef FP32_DENORM_EN
    else if (er[9] || er == 10'd0 || !mr[23])
      rnd_z = {sa_q, 31'd0};
`endif
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    z_d     = z_q;
    res_d   = res_q;
    wr_d    = 1'b0;
    sa_d    = sa_q;
    sb_d    = sb_q;
    spec_d  = spec_q;
    e_d     = e_q;
    eb_d    = eb_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    unique case (state_q)
      IDLE: begin
        if (rd) begin
          x_d     = x;
          y_d     = y;
          op_d    = op;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        sa_d   = x_q[31];
        sb_d   = ysgn;
        e_d    = {2'd0, xee};
        eb_d   = yee;
        ma_d   = {1'b0, xm, 3'd0};
        mb_d   = {ym, 3'd0};
        spec_d = xnan | ynan | xinf | yinf;
        if (xnan)
          res_d = x_q | 32'h0040_0000;
        else if (ynan)
          res_d = y_q | 32'h0040_0000;
        else if (xinf && yinf)
          res_d = (x_q[31] != ysgn) ? 32'h7FC0_0000 : x_q;
        else if (xinf)
          res_d = x_q;
        else if (yinf)
          res_d = {ysgn, y_q[30:0]};
        state_d = ALIGN;
      end
      ALIGN: begin
        ma_d = {1'b0, big_m};
        mb_d = b_al;
        if (swap) begin
          e_d  = {2'd0, eb_q};
          sa_d = sb_q;
          sb_d = sa_q;
        end
        state_d = ADD;
      end
      ADD: begin
        ma_d = sum;
        if (sum == 28'd0)
          sa_d = sa_q & sb_q;
        state_d = NORM;
      end
      NORM: begin
        if (ma_q[27]) begin
          ma_d = {1'b0, ma_q[27:2], ma_q[1] | ma_q[0]};
          e_d  = e_q + 10'd1;
        end else begin
          ma_d = {1'b0, (ma_q[26:0] << sh)};
          e_d  = e_q - {5'd0, sh};
        end
        state_d = ROUND;
      end
      ROUND: begin
        if (!spec_q)
          res_d = rnd_z;
        state_d = DONE;
      end
      DONE: begin
        z_d     = res_q;
        wr_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= 1'b0;
      z_q     <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      spec_q  <= 1'b0;
      e_q     <= '0;
      eb_q    <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      z_q     <= z_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      spec_q  <= spec_d;
      e_q     <= e_d;
      eb_q    <= eb_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
    end
  end

  assign z  = z_q;
  assign wr = wr_q;
endmodule

// File: tb/tb_fp32_adder.sv
// Scoreboard bench for fp32_adder: exact-integer reference model,
// directed vectors plus randomized operands.
module tb_fp32_adder;
  logic        clk, reset, op, rd, wr;
  logic [31:0] x, y, z;

  fp32_adder dut (
    .clk(clk), .reset(reset), .op(op), .rd(rd),
    .x(x), .y(y), .z(z), .wr(wr)
  );

  typedef struct {
    logic [31:0] z;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  // Operand magnitude as an exact integer in units of 2^-149.
  function automatic logic [299:0] mag(input logic [31:0] f);
    logic [299:0] m;
    m = {276'd0, 1'b1, f[22:0]};
    if (f[30:23] == 8'd0) begin
`ifdef FP32_DENORM_EN
      m = {277'd0, f[22:0]};
`else
      m = '0;
`endif
    end else begin
      m = m << (f[30:23] - 1);
    end
    return m;
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic o);
    logic [31:0]  bb, res;
    logic         s;
    logic [299:0] ma, mb, m, keep, rem, half;
    int           p, sh;
    bb = b ^ {o, 31'd0};
    if (&a[30:23] && |a[22:0]) return a | 32'h0040_0000;
    if (&b[30:23] && |b[22:0]) return b | 32'h0040_0000;
    if (&a[30:23] && &bb[30:23])
      return (a[31] != bb[31]) ? 32'h7FC0_0000 : a;
    if (&a[30:23]) return a;
    if (&bb[30:23]) return bb;
    ma = mag(a);
    mb = mag(b);
    if (a[31] == bb[31]) begin m = ma + mb; s = a[31]; end
    else if (ma >= mb) begin m = ma - mb; s = a[31]; end
    else begin m = mb - ma; s = bb[31]; end
    if (m == '0) return {a[31] & bb[31], 31'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    if (p <= 23) begin
      res = {s, m[30:0]};
    end else begin
      sh   = p - 23;
      keep = m >> sh;
      rem  = m & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 300'd1;
      if (keep[24]) begin keep = keep >> 1; sh++; end
      if (sh + 1 >= 255) return {s, 8'hFF, 23'd0};
      res = {s, 8'(sh + 1), keep[22:0]};
    end
`ifndef FP32_DENORM_EN
    if (res[30:23] == 8'd0) res = {s, 31'd0};
`endif
    return res;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'd0;
      1: v[30:0]  = 31'd0;
      2: v[30:23] = 8'hFF;
      3: v[30:0]  = {8'hFF, 23'd0};
      4: v[30:23] = 8'd254 - 8'($urandom_range(0, 2));
      5: v[30:23] = 8'($urandom_range(1, 3));
      default: v[30:23] = 8'($urandom_range(100, 150));
    endcase
    return v;
  endfunction

  // Call at posedge+#1 with the DUT idle; returns likewise.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic o, input logic [31:0] e);
    exp_t t;
    x = a; y = b; op = o; rd = 1'b1;
    @(posedge clk); #1;
    t.z = e; t.acc = cyc; sbq.push_back(t);
    rd = 1'b0; x = $urandom; y = $urandom; op = 1'($urandom);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t        t;
    logic [31:0] last_z;
    last_z = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_z = z;
      end else if (wr) begin
        if (sbq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_wr: got pulse z=%08h required none", z);
        end else begin
          t = sbq.pop_front();
          check("result", z, t.z);
          check("latency", 32'(cyc - t.acc), 32'd6);
        end
        last_z = z;
      end else if (z !== last_z) begin
        n_tests++; n_fail++;
        $display("FAIL z_hold: got %08h required %08h", z, last_z);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, d1, d2, tiny;
    logic        o;
    exp_t        t;
`ifdef FP32_DENORM_EN
    d1 = 32'h0038_8201; d2 = 32'h0028_0000; tiny = 32'h0000_0001;
`else
    d1 = 32'h0; d2 = 32'h0; tiny = 32'h0;
`endif
    reset = 1'b1; rd = 1'b0; op = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_z", z, 32'h0);
    check("reset_wr", {31'd0, wr}, 32'h0);
    reset = 1'b0;

    issue(32'h3F80_0000, 32'h4120_0000, 1'b0, 32'h4130_0000);
    issue(32'h3F80_0000, 32'h5015_02F9, 1'b1, 32'hD015_02F9);
    issue(32'h3F80_0000, 32'hD015_02F9, 1'b0, 32'hD015_02F9);
    issue(32'h3F80_0000, 32'h7FFF_BFC0, 1'b0, 32'h7FFF_BFC0);
    issue(32'h7FFF_BFC0, 32'h3F80_0000, 1'b0, 32'h7FFF_BFC0);
    issue(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000);
    issue(32'hFF80_0000, 32'hFF80_0000, 1'b1, 32'h7FC0_0000);
    issue(32'hFF80_0000, 32'h4120_0000, 1'b0, 32'hFF80_0000);
    issue(32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000);
    issue(32'h4120_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000);
    issue(32'h0028_4100, 32'h0010_4101, 1'b0, d1);
    issue(32'h0038_4101, 32'h0010_4101, 1'b1, d2);
    issue(32'h0080_0001, 32'h0080_0000, 1'b1, tiny);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
    issue(32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000);
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000);
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
    issue(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
    issue(32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001);

    x = 32'h3F80_0000; y = 32'h4120_0000; op = 1'b0; rd = 1'b1;
    @(posedge clk); #1;
    t.z = 32'h4130_0000; t.acc = cyc; sbq.push_back(t);
    repeat (7) @(posedge clk);
    #1;
    t.acc = cyc; sbq.push_back(t);
    rd = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    x = 32'h3F80_0000; y = 32'h4120_0000; op = 1'b0; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_z", z, 32'h0);
    check("abort_wr", {31'd0, wr}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_hold_z", z, 32'h0);
    issue(32'h3F80_0000, 32'h4120_0000, 1'b0, 32'h4130_0000);

    for (int i = 0; i < 400; i++) begin
      a = rnd_fp();
      b = rnd_fp();
      case ($urandom_range(0, 3))
        0: b = {1'($urandom), a[30:0] ^ 31'($urandom_range(0, 255))};
        1: b = a;
        default: ;
      endcase
      o = 1'($urandom);
      issue(a, b, o, ref_add(a, b, o));
    end

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
